// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
// Pure declarations: no latency, no flow control.
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Offset is two's complement, so a plain truncating add gives the mod-2^ADDR_W target.
  function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                   input logic [ADDR_W-1:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: ROM port, instruction stage to decode, redirect/halt from execute.
// Wires only; valid/ready on the instruction stage, ROM answers in the same cycle.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              br_en;
  logic              br_abs;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] br_offset;
  logic              halt_req;

  modport master (
    output rom_addr,
    input  rom_data,
    output inst,
    output inst_pc,
    output inst_valid,
    input  inst_ready,
    input  br_en,
    input  br_abs,
    input  br_target,
    input  br_offset,
    input  halt_req
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  inst,
    input  inst_pc,
    input  inst_valid,
    output inst_ready,
    output br_en,
    output br_abs,
    output br_target,
    output br_offset,
    output halt_req
  );

endinterface

// File: rtl/fetch_target_calc.sv
// Branch target mux: absolute target or base PC plus signed offset, mod 2^ADDR_W.
// Combinational, zero latency; no flow control.
module fetch_target_calc
  import fetch_pkg::*;
(
  input  logic              br_abs_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic [ADDR_W-1:0] br_offset_i,
  input  logic [ADDR_W-1:0] base_pc_i,
  output logic [ADDR_W-1:0] target_o
);

  assign target_o = br_abs_i ? br_target_i : rel_target(base_pc_i, br_offset_i);

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and one-entry registered instruction stage; first instruction 1 cycle after start.
// Decode backpressure (inst_ready low) freezes stage and PC; redirect costs one bubble.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
  parameter int                CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              start,
  fetch_sequencer_if.master bus,
  output logic              done,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_vld_q, inst_vld_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic              xfer;
  logic [ADDR_W-1:0] br_dest;

  fetch_target_calc u_target (
    .br_abs_i    (bus.br_abs),
    .br_target_i (bus.br_target),
    .br_offset_i (bus.br_offset),
    .base_pc_i   (inst_pc_q),
    .target_o    (br_dest)
  );

  // inst_vld_q is only ever set in RUN, so this cannot fire in IDLE or HALTED.
  assign xfer = inst_vld_q && bus.inst_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_vld_d = inst_vld_q;
    done_d     = done_q;
    retired_d  = retired_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          retired_d = '0;
        end
      end
      RUN: begin
        if (xfer && retired_q != CNT_MAX) begin
          retired_d = retired_q + CNT_ONE;
        end
        if (xfer && bus.halt_req) begin
          state_d    = HALTED;
          inst_vld_d = 1'b0;
          done_d     = 1'b1;
        end else if (xfer && bus.br_en) begin
          pc_d       = br_dest;
          inst_vld_d = 1'b0;
        end else if (!inst_vld_q || xfer) begin
          inst_d     = bus.rom_data;
          inst_pc_d  = pc_q;
          inst_vld_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
        end
      end
      HALTED: begin
        if (start) begin
          state_d   = RUN;
          pc_d      = START_ADDR;
          done_d    = 1'b0;
          retired_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= START_ADDR;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      inst_vld_q <= 1'b0;
      done_q     <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_vld_q <= inst_vld_d;
      done_q     <= done_d;
      retired_q  <= retired_d;
    end
  end

  assign bus.rom_addr   = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = inst_vld_q;
  assign done           = done_q;
  assign retired        = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle vector table plus scoreboard of transferred PCs.
// Hand sequences cover start from HALTED and asynchronous reset mid-run.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        CLK;
  logic        rst_n;
  logic        start;
  logic        done;
  logic [15:0] retired;

  fetch_sequencer_if bus();

  fetch_sequencer #(.START_ADDR(8'h00), .CNT_W(16)) dut (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .done    (done),
    .retired (retired)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [8:0] rom_f(input logic [7:0] a);
    return {^a, a ^ 8'hA5};
  endfunction

  assign bus.rom_data = rom_f(bus.rom_addr);

  typedef struct {
    logic        st;
    logic        rdy;
    logic        br;
    logic        babs;
    logic        hlt;
    logic [7:0]  tgt;
    logic [7:0]  off;
    logic        xf;
    logic [7:0]  xpc;
    logic        vld;
    logic [7:0]  ipc;
    logic [7:0]  radr;
    logic        dn;
    logic [15:0] ret;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mk(input logic st, input logic rdy, input logic br, input logic babs,
                              input logic hlt, input logic [7:0] tgt, input logic [7:0] off,
                              input logic xf, input logic [7:0] xpc, input logic vld,
                              input logic [7:0] ipc, input logic [7:0] radr, input logic dn,
                              input logic [15:0] ret);
    vec_t v;
    v.st = st; v.rdy = rdy; v.br = br; v.babs = babs; v.hlt = hlt; v.tgt = tgt; v.off = off;
    v.xf = xf; v.xpc = xpc; v.vld = vld; v.ipc = ipc; v.radr = radr; v.dn = dn; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard pop happens just before the edge on which the transfer commits.
  task automatic tick();
    logic [7:0] e;
    if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_xfer", {24'd0, bus.inst_pc}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("xfer_pc", {24'd0, bus.inst_pc}, {24'd0, e});
        chk("xfer_inst", {23'd0, bus.inst}, {23'd0, rom_f(e)});
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst"}, {23'd0, bus.inst}, 32'd0);
    chk({tag, "_inst_pc"}, {24'd0, bus.inst_pc}, 32'd0);
    chk({tag, "_rom_addr"}, {24'd0, bus.rom_addr}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_retired"}, {16'd0, retired}, 32'd0);
  endtask

  initial begin
    // Stall cycles assert br_en/halt_req to prove they are ignored without a transfer.
    for (int i = 0; i <= 4; i++)
      tbl.push_back(mk(i == 0 ? 1'b0 : (i == 3), 1, 0, 0, 0, 0, 0, i != 0, 8'(i - 1),
                       1, 8'(i), 8'(i + 1), 0, 16'(i)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'd4, 1, 8'd5, 8'd6, 0, 16'd5));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 1, 0, 1, 8'd0, 8'hFC, 0, 0, 1, 8'd5, 8'd6, 0, 16'd5));
    for (int i = 5; i <= 9; i++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 8'(i), 1, 8'(i + 1), 8'(i + 2), 0, 16'(i + 1)));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'd0,   8'hFC, 1, 8'd10,  0, 8'd0,   8'd6,   0, 16'd11));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   1, 8'd6,   8'd7,   0, 16'd11));
    tbl.push_back(mk(0, 1, 1, 1, 0, 8'd200, 8'd0,  1, 8'd6,   0, 8'd0,   8'd200, 0, 16'd12));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   1, 8'd200, 8'd201, 0, 16'd12));
    tbl.push_back(mk(0, 1, 1, 1, 0, 8'd254, 8'd0,  1, 8'd200, 0, 8'd0,   8'd254, 0, 16'd13));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   1, 8'd254, 8'd255, 0, 16'd13));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  1, 8'd254, 1, 8'd255, 8'd0,   0, 16'd14));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  1, 8'd255, 1, 8'd0,   8'd1,   0, 16'd15));
    tbl.push_back(mk(0, 1, 1, 1, 0, 8'd250, 8'd0,  1, 8'd0,   0, 8'd0,   8'd250, 0, 16'd16));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   1, 8'd250, 8'd251, 0, 16'd16));
    tbl.push_back(mk(0, 1, 1, 0, 0, 8'd0,   8'd10, 1, 8'd250, 0, 8'd0,   8'd4,   0, 16'd17));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   1, 8'd4,   8'd5,   0, 16'd17));
    tbl.push_back(mk(0, 1, 1, 1, 1, 8'd100, 8'd0,  1, 8'd4,   0, 8'd0,   8'd5,   1, 16'd18));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'd0,   8'd0,  0, 8'd0,   0, 8'd0,   8'd5,   1, 16'd18));

    rst_n = 1'b0;
    start = 1'b0;
    bus.inst_ready = 1'b0;
    bus.br_en = 1'b0;
    bus.br_abs = 1'b0;
    bus.br_target = '0;
    bus.br_offset = '0;
    bus.halt_req = 1'b0;
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_no_fetch", {31'd0, bus.inst_valid}, 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("start_rom_addr", {24'd0, bus.rom_addr}, 32'd0);

    foreach (tbl[k]) begin
      start = tbl[k].st;
      bus.inst_ready = tbl[k].rdy;
      bus.br_en = tbl[k].br;
      bus.br_abs = tbl[k].babs;
      bus.halt_req = tbl[k].hlt;
      bus.br_target = tbl[k].tgt;
      bus.br_offset = tbl[k].off;
      if (tbl[k].xf) sb.push_back(tbl[k].xpc);
      tick();
      chk($sformatf("v%0d_valid", k), {31'd0, bus.inst_valid}, {31'd0, tbl[k].vld});
      chk($sformatf("v%0d_rom_addr", k), {24'd0, bus.rom_addr}, {24'd0, tbl[k].radr});
      chk($sformatf("v%0d_done", k), {31'd0, done}, {31'd0, tbl[k].dn});
      chk($sformatf("v%0d_retired", k), {16'd0, retired}, {16'd0, tbl[k].ret});
      if (tbl[k].vld) begin
        chk($sformatf("v%0d_inst_pc", k), {24'd0, bus.inst_pc}, {24'd0, tbl[k].ipc});
        chk($sformatf("v%0d_inst", k), {23'd0, bus.inst}, {23'd0, rom_f(tbl[k].ipc)});
      end
    end
    start = 1'b0;
    bus.br_en = 1'b0;
    bus.br_abs = 1'b0;
    bus.halt_req = 1'b0;

    // Restart out of HALTED.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_retired", {16'd0, retired}, 32'd0);
    chk("restart_rom_addr", {24'd0, bus.rom_addr}, 32'd0);
    chk("restart_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("restart_first_pc", {24'd0, bus.inst_pc}, 32'd0);
    chk("restart_first_valid", {31'd0, bus.inst_valid}, 32'd1);
    sb.push_back(8'd0);
    tick();
    chk("restart_retired1", {16'd0, retired}, 32'd1);
    chk("restart_second_pc", {24'd0, bus.inst_pc}, 32'd1);

    // Asynchronous reset between clock edges with an instruction pending.
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("post_rst_idle_addr", {24'd0, bus.rom_addr}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_fetch_pc", {24'd0, bus.inst_pc}, 32'd0);
    chk("post_rst_fetch_valid", {31'd0, bus.inst_valid}, 32'd1);
    bus.inst_ready = 1'b0;
    tick();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and drives the combinational instruction ROM (8-bit address, 9-bit instruction, data valid in the same cycle as the address).
- Holds a one-entry registered instruction stage with a valid/ready handshake toward decode.
- Handles start, halt, stall, and absolute or PC-relative redirects from execute.
- Sits between the instruction ROM and the decode/execute stages.

Parameters:
- ADDR_W, 8, ROM address width; PC width.
- INST_W, 9, instruction width.
- START_ADDR, 8'h00, PC value loaded on reset and on start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins execution from START_ADDR.
- rom_addr  out  ADDR_W  address to instruction ROM; always equals PC.
- rom_data  in  INST_W  instruction returned combinationally for rom_addr.
- inst  out  INST_W  registered instruction presented to decode.
- inst_pc  out  ADDR_W  address that inst was fetched from.
- inst_valid  out  1  inst/inst_pc are valid.
- inst_ready  in  1  decode accepts; a transfer occurs when inst_valid && inst_ready.
- br_en  in  1  redirect request; meaningful only in a transfer cycle.
- br_abs  in  1  1 = absolute target, 0 = PC-relative.
- br_target  in  ADDR_W  absolute target address.
- br_offset  in  ADDR_W  signed two's-complement offset, applied to inst_pc.
- halt_req  in  1  the transferred instruction is a halt; meaningful only in a transfer cycle.
- done  out  1  high while in HALTED.
- retired  out  CNT_W  count of transferred instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; PC = START_ADDR.
  - inst = 0; inst_pc = 0; inst_valid = 0; done = 0; retired = 0.
- States: IDLE, RUN, HALTED.
- IDLE:
  - No fetch occurs; inst_valid = 0.
  - start -> RUN. PC = START_ADDR, retired = 0.
- RUN, fetch rule:
  - If !inst_valid or a transfer occurs this cycle, and no redirect/halt is taken, then:
    - inst <= rom_data; inst_pc <= PC; inst_valid <= 1; PC <= PC + 1.
  - PC increment is modulo 2^ADDR_W (255 -> 0).
  - First valid instruction appears 1 cycle after entering RUN.
- RUN, stall:
  - inst_valid && !inst_ready -> inst, inst_pc, inst_valid and PC hold unchanged.
  - br_en and halt_req are ignored during a stall.
- RUN, redirect (transfer && br_en && !halt_req):
  - Target = br_target if br_abs, else inst_pc + br_offset, truncated mod 2^ADDR_W.
  - PC <= target; inst_valid <= 0. The sequential fetch is squashed: one bubble cycle.
  - The target instruction is valid 2 cycles after the redirect cycle.
- RUN, halt (transfer && halt_req):
  - halt_req has priority over br_en.
  - -> HALTED; inst_valid <= 0; done <= 1; PC holds.
- HALTED:
  - done = 1; no fetch.
  - start -> RUN with PC = START_ADDR, done <= 0, retired <= 0.
- start while in RUN: ignored.
- retired:
  - Increments on every transfer, including the halting and branching instructions.
  - Saturates at 2^CNT_W - 1; no wrap.
- Reset asserted mid-operation: immediate return to reset values; any pending instruction is lost.
- Outputs are registered, except rom_addr = PC, which is itself a register.

Decomposition:
- Shared package `fetch_pkg`:
  - typedef `fetch_state_t` {IDLE, RUN, HALTED}.
  - Constants `ADDR_W`, `INST_W`.
  - Helper function `rel_target(pc, off)` for the mod-256 relative add.
- One natural sub-module: `fetch_target_calc`, a combinational absolute/relative target mux plus adder. Reusable by execute for branch-address debug.
- The remainder is a single module.

Test Plan:
- Reset then start, inst_ready = 1:
  - rom_addr runs 0,1,2,...
  - inst_pc 0,1,2 on consecutive cycles from cycle 1.
  - retired = 3 after 3 transfers.
- Stall: hold inst_ready = 0 for 4 cycles at inst_pc = 5:
  - inst, inst_pc = 5 and PC = 6 are stable for all 4 cycles.
  - Releasing transfers inst_pc 5, then inst_pc 6.
- Relative branch at inst_pc = 10, br_offset = 8'hFC:
  - Next cycle inst_valid = 0.
  - Following cycle inst_pc = 6.
  - br_abs = 1 with br_target = 200 gives inst_pc = 200.
- Wrap:
  - Run from PC 254 -> inst_pc sequence 254, 255, 0.
  - Relative branch at 250 with offset +10 -> inst_pc 4.
- Halt with br_en = 1 in the same transfer:
  - Enters HALTED, done = 1, inst_valid = 0; the branch is ignored.
  - start -> done = 0, retired = 0, fetch resumes at START_ADDR.
- Reset mid-run:
  - rst_n low at an arbitrary cycle with inst_valid = 1 -> outputs go to reset values immediately, without waiting for CLK.
  - State stays IDLE until start.
